// File: rtl/md_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Imported by the unit top and its helpers.
package md_pkg;

  localparam int MD_WIDTH = 32;

  // Every bit of LO is filled with this on divide by zero
  localparam bit MD_DIV0_FILL = 1'b1;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_cond_neg.sv
// Conditional two's-complement negate.
// Used for operand magnitudes and for the final sign fix.
module md_cond_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  assign val_o = neg_i ? (~val_i + ONE) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// One shift-add or shift-subtract step per cycle, then a sign-fix cycle.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic is_div_q, is_div_d;
  logic neg_lo_q, neg_lo_d;
  logic neg_hi_q, neg_hi_d;
  logic div0_q, div0_d;
  logic done_q, done_d;

  logic op_mul, op_div, op_mthi, op_mtlo, op_sgn;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  logic [WIDTH:0] r_sh;
  logic [WIDTH-1:0] r_diff;
  logic r_ge;
  logic [WIDTH:0] m_sum;

  assign op_mul  = (op == MD_MULT) || (op == MD_MULTU);
  assign op_div  = (op == MD_DIV) || (op == MD_DIVU);
  assign op_mthi = (op == MD_MTHI);
  assign op_mtlo = (op == MD_MTLO);
  assign op_sgn  = md_is_signed(op);

  md_cond_neg #(.W(WIDTH)) u_abs_a (
    .val_i (rs_data),
    .neg_i (op_sgn & rs_data[WIDTH-1]),
    .val_o (abs_a)
  );

  md_cond_neg #(.W(WIDTH)) u_abs_b (
    .val_i (rt_data),
    .neg_i (op_sgn & rt_data[WIDTH-1]),
    .val_o (abs_b)
  );

  md_cond_neg #(.W(2*WIDTH)) u_fix_prod (
    .val_i (acc_q),
    .neg_i (neg_lo_q),
    .val_o (prod_fix)
  );

  md_cond_neg #(.W(WIDTH)) u_fix_quo (
    .val_i (acc_q[WIDTH-1:0]),
    .neg_i (neg_lo_q),
    .val_o (quo_fix)
  );

  md_cond_neg #(.W(WIDTH)) u_fix_rem (
    .val_i (rem_q),
    .neg_i (neg_hi_q),
    .val_o (rem_fix)
  );

  // Divide: acc low half shifts the dividend out and quotient bits in
  assign r_sh   = {rem_q, acc_q[WIDTH-1]};
  assign r_ge   = r_sh >= {1'b0, opb_q};
  assign r_diff = r_sh[WIDTH-1:0] - opb_q;

  // Multiply: acc low half holds the multiplier, upper half the sum
  assign m_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, opb_q} : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    done_d   = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (start && !flush) begin
          unique case (1'b1)
            op_mthi: hi_d = rs_data;
            op_mtlo: lo_d = rs_data;
            op_mul, op_div: begin
              state_d  = MD_RUN;
              cnt_d    = '0;
              acc_d    = {{WIDTH{1'b0}}, abs_a};
              rem_d    = '0;
              opb_d    = abs_b;
              is_div_d = op_div;
              neg_lo_d = op_sgn & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
              neg_hi_d = op_sgn & rs_data[WIDTH-1];
              div0_d   = (rt_data == '0);
            end
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          if (is_div_q) begin
            rem_d = r_ge ? r_diff : r_sh[WIDTH-1:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], r_ge};
          end else begin
            acc_d = {m_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = div0_q ? {WIDTH{MD_DIV0_FILL}} : quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != MD_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
